// File: rtl/alu_share_arb.sv
// alu_share_arb
// -------------
// Round-robin arbiter and sequencer that lets two requesters share one
// registered 4-bit ALU (one-cycle result latency). One operation is in flight
// at a time: IDLE grants and latches operands, ISSUE holds the ALU inputs while
// the ALU registers its result, WAIT captures the result, and RESP presents it
// until the consumer takes it.
//
// Optional feature (macro ALU_SHARE_ARB_DIV0_TRAP_EN):
//   When defined, a granted divide (op 011) with b == 0 skips ISSUE/WAIT and
//   answers directly with data 0xFF and err = 1. When undefined, it is issued
//   to the ALU like any other op and err is always 0.
//
// Ports:
//   clk                     rising-edge clock
//   rst_n                   synchronous active-low reset
//   req_valid[1:0]          requester i presents an operation
//   req_ready[1:0]          requester i accepted this cycle (one-hot or zero)
//   req0_op/a/b, req1_op/a/b  per-requester op code (3b) and operands (4b)
//   alu_op, alu_a, alu_b    held inputs to the shared ALU
//   alu_result[7:0]         ALU registered result
//   resp_valid/resp_ready   response handshake
//   resp_data[7:0]          captured result
//   resp_id                 requester that issued the operation
//   resp_err                divide-by-zero trap flag
//   busy                    high whenever the FSM is not in IDLE

module alu_share_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic [2:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [7:0] alu_result,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_data,
  output logic       resp_id,
  output logic       resp_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic       resp_id_q, resp_id_d;
  logic       resp_err_q, resp_err_d;

  // Arbitration: a lone requester always wins; on a conflict the requester
  // that was not granted last wins.
  logic       gnt_any;
  logic       gnt_id;
  logic [2:0] sel_op;
  logic [3:0] sel_a;
  logic [3:0] sel_b;

  always_comb begin
    gnt_id = 1'b0;
    case (req_valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_q;
      default: gnt_id = 1'b0;
    endcase
  end

  // req_ready is combinational and suppressed while reset is asserted.
  assign gnt_any   = rst_n && (state_q == ST_IDLE) && (req_valid != 2'b00);
  assign req_ready = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  assign sel_op = gnt_id ? req1_op : req0_op;
  assign sel_a  = gnt_id ? req1_a  : req0_a;
  assign sel_b  = gnt_id ? req1_b  : req0_b;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          last_d    = gnt_id;
          alu_op_d  = sel_op;
          alu_a_d   = sel_a;
          alu_b_d   = sel_b;
          resp_id_d = gnt_id;
          state_d   = ST_ISSUE;
`ifdef ALU_SHARE_ARB_DIV0_TRAP_EN
          // Divide by zero is answered locally; the ALU inputs are still
          // updated so they always reflect the last granted operation.
          if (sel_op == 3'b011 && sel_b == 4'd0) begin
            resp_data_d = 8'hFF;
            resp_err_d  = 1'b1;
            state_d     = ST_RESP;
          end
`endif
        end
      end
      ST_ISSUE: begin
        // ALU samples the held inputs at this edge.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        resp_data_d = alu_result;
        resp_err_d  = 1'b0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      alu_op_q    <= 3'd0;
      alu_a_q     <= 4'd0;
      alu_b_q     <= 4'd0;
      resp_data_q <= 8'h00;
      resp_id_q   <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb. A stand-in registered ALU drives alu_result.
// Expected responses are pushed to a queue when a grant is observed and are
// popped and compared by a monitor whenever a response handshake completes.

module tb_alu_share_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b;
  logic [7:0] alu_result = 8'h00;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic       resp_id;
  logic       resp_err;
  logic       busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       err;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;

`ifdef ALU_SHARE_ARB_DIV0_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  // Stand-in ALU: one-cycle registered result; divide by zero yields 0xEE.
  always @(posedge clk) begin
    case (alu_op)
      3'b000:  alu_result <= {4'b0, alu_a} + {4'b0, alu_b};
      3'b001:  alu_result <= {4'b0, alu_a} - {4'b0, alu_b};
      3'b010:  alu_result <= {4'b0, alu_a} * {4'b0, alu_b};
      3'b011:  alu_result <= (alu_b == 4'd0) ? 8'hEE : ({4'b0, alu_a} / {4'b0, alu_b});
      3'b100:  alu_result <= {4'b0, alu_a & alu_b};
      3'b101:  alu_result <= {4'b0, alu_a | alu_b};
      default: alu_result <= 8'h00;
    endcase
  end

  // Response monitor: one line per completed response.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      tests++;
      $display("[TB] resp id=%0d data=0x%02h err=%0d", resp_id, resp_data, resp_err);
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got id=%0d data=0x%02h err=%0d, required no response",
                 resp_id, resp_data, resp_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({resp_id, resp_data, resp_err} !== mon_e) begin
          fails++;
          $display("FAIL resp_payload: got id=%0d data=0x%02h err=%0d, required id=%0d data=0x%02h err=%0d",
                   resp_id, resp_data, resp_err, mon_e.id, mon_e.data, mon_e.err);
        end
      end
    end
  end

  // Wait (bounded) until the DUT is idle and all expected responses arrived.
  task automatic settle();
    int cnt = 0;
    while ((busy || exp_q.size() != 0) && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    tests++;
    if (busy || exp_q.size() != 0) begin
      fails++;
      $display("FAIL settle_timeout: busy=%0d pending=%0d, required busy=0 pending=0", busy, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; resp_ready = 1'b0;
    req0_op = 3'd0; req0_a = 4'd1; req0_b = 4'd2;
    req1_op = 3'd0; req1_a = 4'd3; req1_b = 4'd4;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, resp_valid, req_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got busy=%0d resp_valid=%0d req_ready=%b, required 0 0 00", busy, resp_valid, req_ready);
    end
    tests++;
    if ({alu_op, alu_a, alu_b} !== 11'd0) begin
      fails++;
      $display("FAIL reset_alu: got op=%0d a=%0d b=%0d, required 0 0 0", alu_op, alu_a, alu_b);
    end
    tests++;
    if ({resp_data, resp_id, resp_err} !== 10'd0) begin
      fails++;
      $display("FAIL reset_resp: got data=0x%02h id=%0d err=%0d, required 0x00 0 0", resp_data, resp_id, resp_err);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int lat;
    resp_ready = 1'b1;
    req0_op = 3'b000; req0_a = 4'd5; req0_b = 4'd3; req_valid = 2'b01;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL single_grant: got req_ready=%b, required 01", req_ready);
    end
    exp_q.push_back({1'b0, 8'h08, 1'b0});
    @(posedge clk); #1;
    req_valid = 2'b00;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 10);
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL single_latency: got %0d cycles, required 3", lat);
    end
    settle();
  endtask

  task automatic test_contention();
    int cnt;
    rst_n = 1'b0; req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1; resp_ready = 1'b1;
    req0_op = 3'b010; req0_a = 4'd7; req0_b = 4'd6;
    req1_op = 3'b001; req1_a = 4'd9; req1_b = 4'd4;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (req_ready == 2'b00 && cnt < 12);
      tests++;
      if (req_ready !== ((g % 2 == 1) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL contention_grant%0d: got req_ready=%b, required %b", g, req_ready,
                 (g % 2 == 1) ? 2'b10 : 2'b01);
      end
      if (g % 2 == 1) exp_q.push_back({1'b1, 8'h05, 1'b0});
      else            exp_q.push_back({1'b0, 8'h2A, 1'b0});
      if (g > 0) begin
        tests++;
        if (cnt != 4) begin
          fails++;
          $display("FAIL contention_spacing%0d: got %0d cycles between grants, required 4", g, cnt);
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    settle();
  endtask

  task automatic test_backpressure();
    int cnt;
    resp_ready = 1'b0;
    req0_op = 3'b100; req0_a = 4'hC; req0_b = 4'hA; req_valid = 2'b01;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL bp_grant: got req_ready=%b, required 01", req_ready);
    end
    exp_q.push_back({1'b0, 8'h08, 1'b0});
    @(posedge clk); #1;
    req1_op = 3'b101; req1_a = 4'd3; req1_b = 4'd4; req_valid = 2'b10;
    cnt = 0;
    do begin
      @(negedge clk); cnt++;
      tests++;
      if (req_ready !== 2'b00) begin
        fails++;
        $display("FAIL bp_busy_ready: got req_ready=%b at cycle %0d, required 00", req_ready, cnt);
      end
    end while (!resp_valid && cnt < 10);
    tests++;
    if (cnt != 3) begin
      fails++;
      $display("FAIL bp_latency: got %0d cycles, required 3", cnt);
    end
    repeat (5) begin
      @(negedge clk);
      tests++;
      if ({resp_valid, resp_data, resp_id, req_ready} !== {1'b1, 8'h08, 1'b0, 2'b00}) begin
        fails++;
        $display("FAIL bp_hold: got valid=%0d data=0x%02h id=%0d req_ready=%b, required 1 0x08 0 00",
                 resp_valid, resp_data, resp_id, req_ready);
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b00) begin
      fails++;
      $display("FAIL bp_release_ready: got req_ready=%b in handshake cycle, required 00", req_ready);
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("FAIL bp_next_grant: got req_ready=%b, required 10", req_ready);
    end
    exp_q.push_back({1'b1, 8'h07, 1'b0});
    @(posedge clk); #1;
    req_valid = 2'b00;
    settle();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b1;
    req0_op = 3'b000; req0_a = 4'd1; req0_b = 4'd1; req_valid = 2'b01;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL rmid_grant: got req_ready=%b, required 01", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, resp_valid} !== 2'b10) begin
      fails++;
      $display("FAIL rmid_in_wait: got busy=%0d resp_valid=%0d, required 1 0", busy, resp_valid);
    end
    rst_n = 1'b0;
    req0_a = 4'd2; req0_b = 4'd2;
    req1_op = 3'b001; req1_a = 4'd9; req1_b = 4'd4;
    req_valid = 2'b11;
    @(negedge clk);
    tests++;
    if ({busy, resp_valid, req_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL rmid_ctrl: got busy=%0d resp_valid=%0d req_ready=%b, required 0 0 00", busy, resp_valid, req_ready);
    end
    tests++;
    if ({alu_op, alu_a, alu_b, resp_data, resp_id, resp_err} !== 21'd0) begin
      fails++;
      $display("FAIL rmid_regs: got op=%0d a=%0d b=%0d data=0x%02h id=%0d err=%0d, required all 0",
               alu_op, alu_a, alu_b, resp_data, resp_id, resp_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL rmid_regrant: got req_ready=%b, required 01", req_ready);
    end
    exp_q.push_back({1'b0, 8'h04, 1'b0});
    @(posedge clk); #1;
    req_valid = 2'b00;
    settle();
  endtask

  task automatic test_div0();
    int lat;
    resp_ready = 1'b1;
    req1_op = 3'b011; req1_a = 4'd9; req1_b = 4'd0; req_valid = 2'b10;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("FAIL div0_grant: got req_ready=%b, required 10", req_ready);
    end
    if (TRAP) exp_q.push_back({1'b1, 8'hFF, 1'b1});
    else      exp_q.push_back({1'b1, 8'hEE, 1'b0});
    @(posedge clk); #1;
    req_valid = 2'b00;
    tests++;
    if ({alu_op, alu_a, alu_b} !== {3'b011, 4'd9, 4'd0}) begin
      fails++;
      $display("FAIL div0_alu_inputs: got op=%0d a=%0d b=%0d, required 3 9 0", alu_op, alu_a, alu_b);
    end
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 10);
    tests++;
    if (lat != (TRAP ? 1 : 3)) begin
      fails++;
      $display("FAIL div0_latency: got %0d cycles, required %0d", lat, TRAP ? 1 : 3);
    end
    settle();
  endtask

  task automatic test_reserved();
    int lat;
    resp_ready = 1'b1;
    req0_op = 3'b111; req0_a = 4'hF; req0_b = 4'hF; req_valid = 2'b01;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL rsvd_grant: got req_ready=%b, required 01", req_ready);
    end
    exp_q.push_back({1'b0, 8'h00, 1'b0});
    @(posedge clk); #1;
    req_valid = 2'b00;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 10);
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL rsvd_latency: got %0d cycles, required 3", lat);
    end
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_div0();
    test_reserved();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending responses, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
